// File: rtl/stopwatch_mux.sv
// Debounced three-key stopwatch with a DIGITS-wide BCD counter, lap freeze,
// sticky overflow flag and a time-multiplexed common 7-segment display driver.

module stopwatch_debounce #(
    parameter int unsigned CYC = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pulse
);
    localparam int unsigned W = $clog2(CYC + 1);
    localparam logic [W-1:0] SAT = W'(CYC);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!key) begin
            cnt <= '0;
        end else if (cnt != SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Saturation at SAT suppresses repeats until the key drops for a cycle.
    assign pulse = key && (cnt == SAT - 1'b1);
endmodule

module stopwatch_mux #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DEBOUNCE_CYC = 10,
    parameter int unsigned TICK_DIV     = 10,
    parameter int unsigned SCAN_DIV     = 1,
    parameter int unsigned DP_POS       = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_ps,
    input  logic              key_rst,
    input  logic              key_lap,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] dig_en,
    output logic              running,
    output logic              lap_hold,
    output logic              ovf
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = $clog2(DIGITS);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [IW-1:0] DP_IDX    = IW'(DP_POS);
    localparam logic [6:0]    SEG_ZERO  = 7'b1111110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } state_t;

    typedef logic [DIGITS-1:0][3:0] bcd_vec_t;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic pulse_ps;
    logic pulse_rst;
    logic pulse_lap;

    stopwatch_debounce #(.CYC(DEBOUNCE_CYC)) u_db_ps (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_ps),
        .pulse (pulse_ps)
    );

    stopwatch_debounce #(.CYC(DEBOUNCE_CYC)) u_db_rst (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_rst),
        .pulse (pulse_rst)
    );

    stopwatch_debounce #(.CYC(DEBOUNCE_CYC)) u_db_lap (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_lap),
        .pulse (pulse_lap)
    );

    state_t        state;
    logic [PW-1:0] presc;
    bcd_vec_t      digits;
    bcd_vec_t      digits_inc;
    bcd_vec_t      latch;
    bcd_vec_t      disp;
    logic          wrap;
    logic          tick;

    assign tick = (state == S_RUN) && (presc == PRESC_MAX);

    // Ripple-carry BCD increment; wrap is set only when every digit was 9.
    always_comb begin
        logic carry;
        carry      = 1'b1;
        digits_inc = digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (digits[i] >= 4'd9) begin
                    digits_inc[i] = 4'd0;
                end else begin
                    digits_inc[i] = digits[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    // NOTE: non-blocking assignments let the clear branch below simply
    // override the earlier tick/lap updates: the last assignment wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            ovf      <= 1'b0;
            presc    <= '0;
            digits   <= '0;
            latch    <= '0;
        end else begin
            if (state == S_RUN) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
            end

            if (tick) begin
                digits <= digits_inc;
                if (wrap) begin
                    ovf <= 1'b1;
                end
            end

            if (pulse_lap && (state != S_IDLE)) begin
                lap_hold <= !lap_hold;
                if (!lap_hold) begin
                    latch <= digits;
                end
            end

            if (pulse_rst) begin
                state    <= S_IDLE;
                running  <= 1'b0;
                lap_hold <= 1'b0;
                ovf      <= 1'b0;
                presc    <= '0;
                digits   <= '0;
            end else if (pulse_ps) begin
                case (state)
                    S_RUN: begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end
                    default: begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign disp = lap_hold ? latch : digits;

    logic [SW-1:0] scan_cnt;
    logic [IW-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= SEG_ZERO;
            dp       <= (DP_POS == 0);
            dig_en   <= DIGITS'(1);
        end else begin
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg    <= decode(disp[idx]);
            dp     <= (idx == DP_IDX);
            dig_en <= DIGITS'(1) << idx;
        end
    end
endmodule

// File: tb/tb_stopwatch_mux.sv
// Randomised and directed bench for stopwatch_mux against an integer-count
// reference model; a second small instance exercises counter overflow.

module tb_stopwatch_mux;
    localparam int DIGITS = 4;
    localparam int DEB    = 10;
    localparam int TICK   = 10;
    localparam int SCAN   = 3;
    localparam int DP     = 2;
    localparam int MAXV   = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, key_ps, key_rst, key_lap;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] dig_en;
    logic              running, lap_hold, ovf;

    logic       o_rst_n, o_key_ps, o_key_rst, o_key_lap;
    logic [6:0] o_seg;
    logic       o_dp;
    logic [1:0] o_dig_en;
    logic       o_running, o_lap_hold, o_ovf;

    stopwatch_mux #(
        .DIGITS(DIGITS), .DEBOUNCE_CYC(DEB), .TICK_DIV(TICK), .SCAN_DIV(SCAN), .DP_POS(DP)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .key_ps(key_ps), .key_rst(key_rst), .key_lap(key_lap),
        .seg(seg), .dp(dp), .dig_en(dig_en), .running(running), .lap_hold(lap_hold), .ovf(ovf)
    );

    stopwatch_mux #(
        .DIGITS(2), .DEBOUNCE_CYC(2), .TICK_DIV(1), .SCAN_DIV(1), .DP_POS(0)
    ) u_ovf (
        .clk(clk), .rst_n(o_rst_n), .key_ps(o_key_ps), .key_rst(o_key_rst), .key_lap(o_key_lap),
        .seg(o_seg), .dp(o_dp), .dig_en(o_dig_en), .running(o_running), .lap_hold(o_lap_hold),
        .ovf(o_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec7(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int digit_of(input int v, input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p *= 10;
        return (v / p) % 10;
    endfunction

    // Reference model: elapsed time as a plain integer modulo 10^DIGITS,
    // keys tracked as consecutive-high run lengths.
    int   m_state = 0;  // 0 idle, 1 run, 2 pause
    int   m_run [3];
    int   m_presc = 0, m_count = 0, m_latch = 0, m_idx = 0, m_scan = 0;
    bit   m_ovf = 0, m_hold = 0, model_ok = 0;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_dig;

    always @(posedge clk) begin
        int shown, count_pre;
        bit p_ps, p_rst, p_lap, tick;
        shown = m_hold ? m_latch : m_count;
        if (!rst_n) begin
            m_state = 0; m_presc = 0; m_count = 0; m_latch = 0; m_idx = 0; m_scan = 0;
            m_ovf = 0; m_hold = 0;
            for (int k = 0; k < 3; k++) m_run[k] = 0;
            e_seg = 7'b1111110; e_dig = 4'b0001; e_dp = (DP == 0);
            model_ok = 1;
        end else begin
            e_seg = dec7(digit_of(shown, m_idx));
            e_dig = 4'(1 << m_idx);
            e_dp  = (m_idx == DP);
            m_run[0] = key_ps  ? m_run[0] + 1 : 0;
            m_run[1] = key_rst ? m_run[1] + 1 : 0;
            m_run[2] = key_lap ? m_run[2] + 1 : 0;
            p_ps  = (m_run[0] == DEB);
            p_rst = (m_run[1] == DEB);
            p_lap = (m_run[2] == DEB);
            tick = (m_state == 1) && (m_presc == TICK - 1);
            count_pre = m_count;
            if (m_state == 1) m_presc = (m_presc + 1) % TICK;
            if (tick) begin
                if (m_count == MAXV - 1) m_ovf = 1;
                m_count = (m_count + 1) % MAXV;
            end
            if (p_lap && m_state != 0) begin
                if (!m_hold) m_latch = count_pre;
                m_hold = !m_hold;
            end
            if (p_rst) begin
                m_state = 0; m_count = 0; m_presc = 0; m_ovf = 0; m_hold = 0;
            end else if (p_ps) begin
                m_state = (m_state == 1) ? 2 : 1;
            end
            m_scan++;
            if (m_scan == SCAN) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % DIGITS;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("running", running, m_state == 1);
            check("lap_hold", lap_hold, m_hold);
            check("ovf", ovf, m_ovf);
            check("seg", seg, e_seg);
            check("dig_en", dig_en, e_dig);
            check("dp", dp, e_dp);
        end
    end

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_ps = v;
            1: key_rst = v;
            2: key_lap = v;
            3: o_key_ps = v;
            default: o_key_rst = v;
        endcase
    endtask

    task automatic press(input int k, input int len);
        set_key(k, 1'b1);
        repeat (len) @(negedge clk);
        set_key(k, 1'b0);
    endtask

    task automatic check_shown(input string tag, input int v);
        repeat (2 * DIGITS * SCAN) begin
            @(negedge clk);
            for (int i = 0; i < DIGITS; i++) begin
                if (dig_en == 4'(1 << i)) begin
                    check({tag, "_seg"}, seg, dec7(digit_of(v, i)));
                    check({tag, "_dp"}, dp, i == DP);
                end
            end
        end
    endtask

    initial begin
        int n, len;
        rst_n = 0; key_ps = 0; key_rst = 0; key_lap = 0;
        o_rst_n = 0; o_key_ps = 0; o_key_rst = 0; o_key_lap = 0;
        repeat (2) @(negedge clk);
        check("rst_seg", seg, 7'b1111110);
        check("rst_dig_en", dig_en, 4'b0001);
        check("rst_dp", dp, 1'b0);
        check("rst_running", running, 1'b0);
        rst_n = 1; o_rst_n = 1;

        // Overflow on the 2-digit, tick-every-cycle instance.
        press(3, 2);
        check("ovf_run", o_running, 1'b1);
        n = 0;
        for (int c = 0; c < 300 && !o_ovf; c++) begin
            if (o_running) n++;
            @(negedge clk);
        end
        check("ovf_ticks", n, 100);
        check("ovf_set", o_ovf, 1'b1);
        @(negedge clk);
        check("ovf_digits_00", o_seg, 7'b1111110);
        press(4, 2);
        check("ovf_clear", o_ovf, 1'b0);
        check("ovf_idle", o_running, 1'b0);

        // Key glitch shorter than the debounce window.
        press(0, 9);
        @(negedge clk);
        press(0, 9);
        repeat (3) @(negedge clk);
        check("glitch_idle", running, 1'b0);

        // Count 100 ticks exactly, then pause and hold.
        press(0, 10);
        check("start_run", running, 1'b1);
        repeat (990) @(negedge clk);
        press(0, 10);
        check("paused", running, 1'b0);
        repeat (500) @(negedge clk);
        check_shown("count_0100", 100);

        press(1, 10);
        check("clear_idle", running, 1'b0);
        check_shown("clear_0000", 0);

        // Lap at 0037, keep counting past 0050, release while paused.
        press(0, 10);
        repeat (365) @(negedge clk);
        press(2, 10);
        check("lap_on", lap_hold, 1'b1);
        repeat (130) @(negedge clk);
        check_shown("lap_0037", 37);
        press(0, 10);
        press(2, 10);
        check("lap_off", lap_hold, 1'b0);
        check_shown("lap_live", m_count);

        // Clear and start/pause qualifying together in RUN.
        press(0, 10);
        repeat (20) @(negedge clk);
        set_key(0, 1'b1); set_key(1, 1'b1);
        repeat (10) @(negedge clk);
        set_key(0, 1'b0); set_key(1, 1'b0);
        check("prio_idle", running, 1'b0);
        check_shown("prio_0000", 0);

        // Reset mid-count with start/pause held through it.
        press(0, 10);
        repeat (57) @(negedge clk);
        key_ps = 1;
        repeat (4) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        check("mid_rst_running", running, 1'b0);
        check("mid_rst_hold", lap_hold, 1'b0);
        check("mid_rst_ovf", ovf, 1'b0);
        check("mid_rst_seg", seg, 7'b1111110);
        check("mid_rst_dig_en", dig_en, 4'b0001);
        check("mid_rst_dp", dp, 1'b0);
        rst_n = 1;
        repeat (9) @(negedge clk);
        check("requal_wait", running, 1'b0);
        @(negedge clk);
        check("requal_run", running, 1'b1);
        key_ps = 0;

        // Random key activity against the model.
        n = 0;
        while (n < 3000) begin
            if ($urandom_range(0, 99) < 2) begin
                rst_n = 0;
                @(negedge clk);
                rst_n = 1;
                n++;
            end
            key_ps  = ($urandom_range(0, 9) < 4);
            key_rst = ($urandom_range(0, 9) < 1);
            key_lap = ($urandom_range(0, 9) < 3);
            len = $urandom_range(1, 25);
            repeat (len) @(negedge clk);
            n += len;
        end
        key_ps = 0; key_rst = 0; key_lap = 0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
